reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
// - 2-read / 1-write general-purpose register file for the single-cycle CPU datapath.
// - Decode reads operands on ports 1 and 2 (ra1/ra2 -> rd1/rd2); writeback uses port 3 (wa3/wd3/we3).
// - Reads are combinational. Writes commit on the FALLING edge of clk.
// - A value written in a cycle is visible for the rest of that cycle, and never before the falling edge.
// PARAMETERS
// - DATA_W   32   width of each register and of the read/write data ports
// - ADDR_W   5    address width; depth = 2**ADDR_W (32 entries)
// PORTS
// - clk    in   1       single clock; write commit on negedge
// - rst_n  in   1       reset, asynchronous, active-low
// - we3    in   1       write enable for port 3
// - wa3    in   ADDR_W  write address
// - wd3    in   DATA_W  write data
// - ra1    in   ADDR_W  read address, port 1
// - ra2    in   ADDR_W  read address, port 2
// - rd1    out  DATA_W  read data, port 1 = regs[ra1], combinational
// - rd2    out  DATA_W  read data, port 2 = regs[ra2], combinational
// - Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
// BEHAVIOUR
// - Storage: 2**ADDR_W x DATA_W flip-flop array. No latches, no clock gating.
// - Reset: rst_n low clears every entry to 0 immediately, without waiting for a clock edge.
//   - Reset holds the entries at 0 while low; rd1/rd2 read 0 for any address.
//   - Reset overrides a write at the same edge. Deassertion is not synchronised internally.
// - Write: on negedge clk with rst_n high and we3=1, regs[wa3] <= wd3.
//   - Write latency: 1 falling edge.
//   - we3=0 leaves all entries unchanged. All of wa3/wd3 is sampled at that edge only.
// - Read: rd1/rd2 follow ra1/ra2 and the array contents combinationally.
//   - Read latency: 0 cycles. No registered outputs, no handshake.
// - Read during write, same address:
//   - Between the rising edge and the falling edge, the read returns the OLD value.
//   - After the falling edge commit, the read returns the NEW value in the same cycle.
//   - No combinational bypass of wd3 to rd1/rd2.
// - Both read ports may address the same entry, or the write address, at once. All reads are independent and correct.
// - All addresses 0..2**ADDR_W-1 are valid. Addresses do not wrap or alias.
// - Register 0 is governed by the CONFIGURATION block.
// CONFIGURATION
// - Macro R0_ZERO_EN:
//   - Defined: entry 0 is hardwired zero. rd1/rd2 return 0 when their address is 0. Writes to wa3=0 are discarded.
//   - Undefined (default): entry 0 is an ordinary read/write register.
// TESTING
// - Apply stimulus away from clk edges; check after propagation.
// - T1 reset:
//   - Write 0xFFFFFFFF to regs 1..31, pulse rst_n low mid-cycle (no clk edge).
//   - Required: rd1/rd2 = 0 for every address while low and after release.
// - T2 write/read:
//   - we3=1, wa3=5, wd3=0xDEADBEEF across a negedge; then we3=0, ra1=5.
//   - Required: rd1 = 0xDEADBEEF before the next posedge.
// - T3 old-value window:
//   - Reg5 = 0xDEADBEEF. After a negedge set ra1=5, wa3=5, wd3=0xCAFEBABE, we3=1.
//   - Required: rd1 = 0xDEADBEEF 1 ns after the next posedge.
//   - Required: rd1 = 0xCAFEBABE 1 ns after the following negedge.
// - T4 dual read:
//   - Regs 3 = 0x11111111 and 7 = 0x22222222. ra1=3, ra2=7.
//   - Required: rd1 = 0x11111111, rd2 = 0x22222222. Swap addresses -> outputs swap with 0 latency.
// - T5 we3 low:
//   - we3=0, wa3=5, wd3=0x0BADF00D over 3 negedges.
//   - Required: reg5 unchanged. Writes to regs 0 and 31 land only in their own entries.
// - T6 reg0:
//   - Write 0x12345678 to wa3=0, then ra1=0.
//   - Required: rd1 = 0x12345678 without R0_ZERO_EN; rd1 = 0 with R0_ZERO_EN.

Source files
------------

// File: rtl/reg_file.sv
// Two-read / one-write register file; writes commit on the falling clock edge.
// Optional macro R0_ZERO_EN makes entry 0 a hardwired zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

`ifdef R0_ZERO_EN
    assign wr_ok = (wa3 != '0);
`else
    assign wr_ok = 1'b1;
`endif

    // Falling-edge commit gives decode the second half-cycle to see writeback data.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && wr_ok) begin
            regs[wa3] <= wd3;
        end
    end

`ifdef R0_ZERO_EN
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`else
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus random traffic vs. an array model.
// Honours R0_ZERO_EN when computing expected register-0 reads.
`timescale 1ns/100ps
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int total;
    int bad;

    logic [31:0] mdl [32];

    reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mrd(input int a);
`ifdef R0_ZERO_EN
        if (a == 0) return 32'h0;
`endif
        return mdl[a];
    endfunction

    function automatic void mwr(input int a, input logic [31:0] d);
`ifdef R0_ZERO_EN
        if (a == 0) return;
`endif
        mdl[a] = d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a write mid-high-phase, let it cross one negedge, then update the model.
    task automatic wr(input int a, input logic [31:0] d);
        @(posedge clk);
        #2;
        we3 = 1'b1;
        wa3 = 5'(a);
        wd3 = d;
        @(negedge clk);
        #1;
        we3 = 1'b0;
        mwr(a, d);
    endtask

    initial begin
        logic [31:0] v;
        int a;
        int b;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        ra1 = '0;
        ra2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        #12;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i += 7) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #0.5;
            chk("reset_state_rd1", rd1, 32'h0);
            chk("reset_state_rd2", rd2, 32'h0);
        end

        // T1: fill, then asynchronous reset pulse away from any edge
        for (int i = 1; i < 32; i++) wr(i, 32'hFFFF_FFFF);
        ra1 = 5'd9;
        #0.5;
        chk("t1_prefill", rd1, mrd(9));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #0.25;
            chk("t1_rst_low_rd1", rd1, 32'h0);
            chk("t1_rst_low_rd2", rd2, 32'h0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #0.05;
            chk("t1_rst_rel_rd1", rd1, 32'h0);
            chk("t1_rst_rel_rd2", rd2, 32'h0);
        end

        // T2: write then read before the next rising edge
        wr(5, 32'hDEAD_BEEF);
        ra1 = 5'd5;
        #0.5;
        chk("t2_read_back", rd1, 32'hDEAD_BEEF);

        // T3: old value until the falling edge, new value after it
        @(negedge clk);
        #1;
        ra1 = 5'd5;
        wa3 = 5'd5;
        wd3 = 32'hCAFE_BABE;
        we3 = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_old_value", rd1, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        we3 = 1'b0;
        mwr(5, 32'hCAFE_BABE);
        chk("t3_new_value", rd1, 32'hCAFE_BABE);

        // T4: dual read and address swap
        wr(3, 32'h1111_1111);
        wr(7, 32'h2222_2222);
        ra1 = 5'd3;
        ra2 = 5'd7;
        #0.5;
        chk("t4_rd1", rd1, 32'h1111_1111);
        chk("t4_rd2", rd2, 32'h2222_2222);
        ra1 = 5'd7;
        ra2 = 5'd3;
        #0.1;
        chk("t4_swap_rd1", rd1, 32'h2222_2222);
        chk("t4_swap_rd2", rd2, 32'h1111_1111);

        // T5: we3 low across three falling edges, then edge entries
        @(posedge clk);
        #2;
        we3 = 1'b0;
        wa3 = 5'd5;
        wd3 = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        #1;
        ra1 = 5'd5;
        #0.5;
        chk("t5_we_low", rd1, 32'hCAFE_BABE);
        wr(0, 32'hA5A5_0000);
        wr(31, 32'h0000_5A5A);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #0.05;
            chk("t5_all_rd1", rd1, mrd(i));
            chk("t5_all_rd2", rd2, mrd(i));
        end

        // T6: register 0 behaviour depends on the build
        wr(0, 32'h1234_5678);
        ra1 = 5'd0;
        #0.5;
`ifdef R0_ZERO_EN
        chk("t6_reg0", rd1, 32'h0);
`else
        chk("t6_reg0", rd1, 32'h1234_5678);
`endif

        // Random traffic: check old value before the fall, new value after
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #2;
            a = int'($urandom_range(31));
            b = int'($urandom_range(31));
            v = $urandom;
            we3 = ($urandom_range(3) != 0);
            wa3 = ($urandom_range(3) == 0) ? 5'(a) : 5'($urandom_range(31));
            wd3 = v;
            ra1 = 5'(a);
            ra2 = 5'(b);
            #1;
            chk("rnd_pre_rd1", rd1, mrd(a));
            chk("rnd_pre_rd2", rd2, mrd(b));
            @(negedge clk);
            if (we3) mwr(int'(wa3), wd3);
            #1;
            chk("rnd_post_rd1", rd1, mrd(a));
            chk("rnd_post_rd2", rd2, mrd(b));
            we3 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
